// File: rtl/sio_host_pkg.sv
// Shared definitions for the escaped-serial memory protocol, used by both
// the host (initiator) and the device-side protocol block.
package sio_defs;

    localparam int CMD_W  = 4;
    localparam int ADDR_W = 20;
    localparam int LEN_W  = 17;

    typedef logic [CMD_W-1:0] cmd_t;

    localparam cmd_t CMD_PING     = 4'd0;
    localparam cmd_t CMD_WRITE    = 4'd1;
    localparam cmd_t CMD_READ_16  = 4'd2;
    localparam cmd_t CMD_READ_1K  = 4'd3;
    localparam cmd_t CMD_READ_64K = 4'd4;

    // Three header bytes following the opening flag, in wire order.
    typedef struct packed {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } sio_hdr_t;

    function automatic logic [LEN_W-1:0] reply_len(input cmd_t cmd);
        case (cmd)
            CMD_READ_16:  reply_len = 17'd16;
            CMD_READ_1K:  reply_len = 17'd1024;
            CMD_READ_64K: reply_len = 17'd65536;
            default:      reply_len = 17'd0;
        endcase
    endfunction

    function automatic sio_hdr_t make_hdr(input cmd_t cmd, input logic [ADDR_W-1:0] addr);
        make_hdr.b0 = {cmd, addr[19:16]};
        make_hdr.b1 = addr[15:8];
        make_hdr.b2 = addr[7:0];
    endfunction

endpackage

// File: rtl/sio_host_rx.sv
// Reply parser for sio_host: checks the echoed header, forwards data bytes,
// and raises a one-cycle error on bad header, stray flag or reply silence.
//
// state     | meaning
// IDLE      | no command, or command already aborted
// WAIT_FLAG | waiting for the reply's opening flag
// H0..H2    | comparing echoed header bytes
// DATA      | forwarding reply bytes, counting down
// FIN       | reply complete; waiting for the top level to finish
module sio_host_rx
    import sio_defs::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd12000000
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             start,
    input  logic             busy,
    input  sio_hdr_t         hdr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_strobe,
    input  logic             rx_flag,
    output logic [7:0]       rd_data,
    output logic             rd_strobe,
    output logic             fin,
    output logic             err
);

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_WAIT_FLAG = 3'd1;
    localparam logic [2:0] RX_H0        = 3'd2;
    localparam logic [2:0] RX_H1        = 3'd3;
    localparam logic [2:0] RX_H2        = 3'd4;
    localparam logic [2:0] RX_DATA      = 3'd5;
    localparam logic [2:0] RX_FIN       = 3'd6;

    logic [2:0]       state;
    logic [LEN_W-1:0] remaining;
    logic [23:0]      tcnt;
    logic [7:0]       exp_byte;
    logic             rx_event;
    logic             timeout_hit;

    assign rx_event    = rx_data_strobe || rx_flag;
    assign timeout_hit = (tcnt == TIMEOUT - 24'd1) && !rx_event;
    assign fin         = (state == RX_FIN);

    always_comb begin
        exp_byte = hdr.b2;
        case (state)
            RX_H0:   exp_byte = hdr.b0;
            RX_H1:   exp_byte = hdr.b1;
            default: exp_byte = hdr.b2;
        endcase
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state     <= RX_IDLE;
            remaining <= '0;
            tcnt      <= '0;
            rd_data   <= '0;
            rd_strobe <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_strobe <= 1'b0;
            err       <= 1'b0;
            if (start) begin
                state <= RX_WAIT_FLAG;
                tcnt  <= '0;
            end else if (!busy || state == RX_IDLE) begin
                state <= RX_IDLE;
                tcnt  <= '0;
            end else begin
                tcnt <= rx_event ? 24'd0 : tcnt + 24'd1;
                if (timeout_hit) begin
                    err   <= 1'b1;
                    state <= RX_IDLE;
                end else begin
                    case (state)
                        RX_WAIT_FLAG: if (rx_flag) state <= RX_H0;
                        RX_H0, RX_H1, RX_H2: begin
                            // flag wins over a simultaneous data strobe
                            if (rx_flag) begin
                                err   <= 1'b1;
                                state <= RX_IDLE;
                            end else if (rx_data_strobe) begin
                                if (rx_data != exp_byte) begin
                                    err   <= 1'b1;
                                    state <= RX_IDLE;
                                end else if (state == RX_H2) begin
                                    remaining <= len;
                                    state     <= (len == '0) ? RX_FIN : RX_DATA;
                                end else begin
                                    state <= state + 3'd1;
                                end
                            end
                        end
                        RX_DATA: begin
                            if (rx_flag) begin
                                err   <= 1'b1;
                                state <= RX_IDLE;
                            end else if (rx_data_strobe) begin
                                rd_data   <= rx_data;
                                rd_strobe <= 1'b1;
                                remaining <= remaining - 17'd1;
                                if (remaining == 17'd1) state <= RX_FIN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/sio_host.sv
// Initiator side of the escaped-serial memory protocol: sends command
// packets to the UART and hands the reply stream to sio_host_rx.
//
// state | meaning
// IDLE  | nothing to send
// FLAG  | opening flag
// HDR0  | {cmd, addr[19:16]}
// HDR1  | addr[15:8]
// HDR2  | addr[7:0]
// WDATA | streaming write bytes from the requester
// WFLAG | closing flag after write data (or on abort mid-write)
module sio_host
    import sio_defs::*;
#(
    parameter logic [23:0] TIMEOUT = 24'd12000000
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [19:0] req_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    input  logic        wr_last,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_strobe,
    output logic        done,
    output logic        err,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_strobe,
    output logic        tx_flag,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_strobe,
    input  logic        rx_flag
);

    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_FLAG  = 3'd1;
    localparam logic [2:0] TX_HDR0  = 3'd2;
    localparam logic [2:0] TX_HDR1  = 3'd3;
    localparam logic [2:0] TX_HDR2  = 3'd4;
    localparam logic [2:0] TX_WDATA = 3'd5;
    localparam logic [2:0] TX_WFLAG = 3'd6;

    logic [2:0]        tx_state;
    logic              busy;
    logic              aborting;
    logic              prev_tx;
    logic              accept;
    logic              issue_ok;
    logic              tx_sent;
    logic              rx_fin;
    logic              rx_err;
    cmd_t              cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    sio_hdr_t          hdr;

    assign req_ready = !busy;
    assign accept    = req_valid && !busy;
    assign hdr       = make_hdr(cmd_q, addr_q);
    // UART needs a quiet cycle between consecutive strobes/flags
    assign issue_ok  = tx_ready && !prev_tx;
    assign tx_sent   = tx_data_strobe || tx_flag;
    assign err       = rx_err;

    always_comb begin
        tx_flag        = 1'b0;
        tx_data_strobe = 1'b0;
        tx_data        = '0;
        wr_ready       = 1'b0;
        case (tx_state)
            TX_FLAG, TX_WFLAG: tx_flag = issue_ok;
            TX_HDR0: begin
                tx_data_strobe = issue_ok;
                tx_data        = hdr.b0;
            end
            TX_HDR1: begin
                tx_data_strobe = issue_ok;
                tx_data        = hdr.b1;
            end
            TX_HDR2: begin
                tx_data_strobe = issue_ok;
                tx_data        = hdr.b2;
            end
            TX_WDATA: begin
                tx_data_strobe = issue_ok && wr_valid;
                wr_ready       = issue_ok && wr_valid;
                tx_data        = wr_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            busy     <= 1'b0;
            aborting <= 1'b0;
            prev_tx  <= 1'b0;
            done     <= 1'b0;
            cmd_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
        end else begin
            prev_tx <= tx_sent;
            done    <= 1'b0;
            if (accept) begin
                busy     <= 1'b1;
                aborting <= 1'b0;
                cmd_q    <= req_cmd;
                addr_q   <= req_addr;
                len_q    <= reply_len(req_cmd);
                tx_state <= TX_FLAG;
            end else if (busy) begin
                case (tx_state)
                    TX_FLAG:  if (tx_sent) tx_state <= TX_HDR0;
                    TX_HDR0:  if (tx_sent) tx_state <= TX_HDR1;
                    TX_HDR1:  if (tx_sent) tx_state <= TX_HDR2;
                    TX_HDR2:  if (tx_sent) tx_state <= (cmd_q == CMD_WRITE) ? TX_WDATA : TX_IDLE;
                    TX_WDATA: if (tx_sent && wr_last) tx_state <= TX_WFLAG;
                    TX_WFLAG: if (tx_sent) tx_state <= TX_IDLE;
                    default: ;
                endcase
                if (rx_err) begin
                    // a write in progress still gets its closing flag
                    aborting <= 1'b1;
                    if (tx_state == TX_WDATA)
                        tx_state <= TX_WFLAG;
                    else if (tx_state != TX_WFLAG)
                        tx_state <= TX_IDLE;
                end else if (tx_state == TX_IDLE) begin
                    if (aborting) begin
                        busy     <= 1'b0;
                        aborting <= 1'b0;
                    end else if (rx_fin) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end
        end
    end

    sio_host_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .mclk           (mclk),
        .reset          (reset),
        .start          (accept),
        .busy           (busy),
        .hdr            (hdr),
        .len            (len_q),
        .rx_data        (rx_data),
        .rx_data_strobe (rx_data_strobe),
        .rx_flag        (rx_flag),
        .rd_data        (rd_data),
        .rd_strobe      (rd_strobe),
        .fin            (rx_fin),
        .err            (rx_err)
    );

endmodule

// File: tb/tb_sio_host.sv
// Directed bench for sio_host: drives commands and scripted replies, and
// checks the transmitted packet, reply data and done/err pulses.
module tb_sio_host;

    logic        mclk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [19:0] req_addr;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_last;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_strobe;
    logic        done;
    logic        err;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_data_strobe;
    logic        tx_flag;
    logic [7:0]  rx_data;
    logic        rx_data_strobe;
    logic        rx_flag;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] txq[$];
    logic [7:0] rdq[$];
    int wr_cnt      = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int rule_viol   = 0;
    int cyc         = 0;
    int last_rd_cyc = 0;
    int err_cyc     = 0;
    bit prev_tx_seen = 1'b0;

    always #5 mclk = ~mclk;

    sio_host #(
        .TIMEOUT (24'd100)
    ) dut (
        .mclk           (mclk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cmd        (req_cmd),
        .req_addr       (req_addr),
        .wr_data        (wr_data),
        .wr_valid       (wr_valid),
        .wr_last        (wr_last),
        .wr_ready       (wr_ready),
        .rd_data        (rd_data),
        .rd_strobe      (rd_strobe),
        .done           (done),
        .err            (err),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx_data_strobe (tx_data_strobe),
        .tx_flag        (tx_flag),
        .rx_data        (rx_data),
        .rx_data_strobe (rx_data_strobe),
        .rx_flag        (rx_flag)
    );

    // Flags recorded as 9'h100 so they are distinct from any data byte.
    always @(negedge mclk) begin
        if (tx_flag) txq.push_back(9'h100);
        if (tx_data_strobe) txq.push_back({1'b0, tx_data});
        if ((tx_flag || tx_data_strobe) && (!tx_ready || prev_tx_seen || (tx_flag && tx_data_strobe)))
            rule_viol <= rule_viol + 1;
        prev_tx_seen <= tx_flag || tx_data_strobe;
        if (wr_ready) wr_cnt <= wr_cnt + 1;
        if (rd_strobe) begin
            rdq.push_back(rd_data);
            last_rd_cyc <= cyc;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int tx_at(input int i);
        if (i < txq.size()) return int'(txq[i]);
        return 32'h1FF;
    endfunction

    task automatic start_cmd(input logic [3:0] c, input logic [19:0] a);
        @(posedge mclk); #1;
        req_cmd   = c;
        req_addr  = a;
        req_valid = 1'b1;
        @(posedge mclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge mclk); #1;
        rx_data        = b;
        rx_data_strobe = 1'b1;
        @(posedge mclk); #1;
        rx_data_strobe = 1'b0;
    endtask

    task automatic rx_flg();
        @(posedge mclk); #1;
        rx_flag = 1'b1;
        @(posedge mclk); #1;
        rx_flag = 1'b0;
    endtask

    task automatic put_wr(input logic [7:0] b, input logic last);
        bit got = 1'b0;
        int n = 0;
        @(posedge mclk); #1;
        wr_data  = b;
        wr_valid = 1'b1;
        wr_last  = last;
        while (!got && n < 200) begin
            @(negedge mclk);
            if (wr_ready) got = 1'b1;
            n++;
        end
        @(posedge mclk); #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        check_eq("wr_accept", int'(got), 1);
    endtask

    task automatic wait_end(input int limit, input int base, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge mclk); #1;
            if (done_cnt + err_cnt > base) hit = 1'b1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_req_ready"}, int'(req_ready), 1);
        check_eq({tag, "_pulses"}, int'({done, err, rd_strobe, wr_ready, tx_flag, tx_data_strobe}), 0);
        check_eq({tag, "_data"}, int'({tx_data, rd_data}), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  b_tx, b_rd, b_d, b_e, b_wr, bad;
        bit  hit;

        reset = 1'b1;
        req_valid = 1'b0; req_cmd = '0; req_addr = '0;
        wr_data = '0; wr_valid = 1'b0; wr_last = 1'b0;
        tx_ready = 1'b1;
        rx_data = '0; rx_data_strobe = 1'b0; rx_flag = 1'b0;
        repeat (3) @(posedge mclk);
        @(negedge mclk); #1;
        check_idle_outputs("reset");
        @(posedge mclk); #1;
        reset = 1'b0;
        repeat (2) @(posedge mclk);

        // ping 0x12345
        b_tx = txq.size(); b_rd = rdq.size(); b_d = done_cnt; b_e = err_cnt;
        start_cmd(4'd0, 20'h12345);
        check_eq("ping_req_ready_drop", int'(req_ready), 0);
        repeat (12) @(posedge mclk);
        #1;
        check_eq("ping_tx_len", txq.size() - b_tx, 4);
        check_eq("ping_tx0", tx_at(b_tx),     32'h100);
        check_eq("ping_tx1", tx_at(b_tx + 1), 32'h01);
        check_eq("ping_tx2", tx_at(b_tx + 2), 32'h23);
        check_eq("ping_tx3", tx_at(b_tx + 3), 32'h45);
        rx_flg();
        rx_byte(8'h01); rx_byte(8'h23); rx_byte(8'h45);
        wait_end(50, b_d + b_e, hit);
        check_eq("ping_end", int'(hit), 1);
        check_eq("ping_done", done_cnt - b_d, 1);
        check_eq("ping_err", err_cnt - b_e, 0);
        check_eq("ping_rd", rdq.size() - b_rd, 0);
        check_eq("ping_req_ready", int'(req_ready), 1);

        // read16 0x00100 with a tx_ready stall and a stray byte before the flag
        b_tx = txq.size(); b_rd = rdq.size(); b_d = done_cnt; b_e = err_cnt;
        start_cmd(4'd2, 20'h00100);
        tx_ready = 1'b0;
        repeat (5) @(posedge mclk);
        #1;
        tx_ready = 1'b1;
        rx_byte(8'h77);
        rx_flg();
        rx_byte(8'h20); rx_byte(8'h01); rx_byte(8'h00);
        for (int i = 0; i < 16; i++) rx_byte(8'(i));
        wait_end(100, b_d + b_e, hit);
        check_eq("rd16_end", int'(hit), 1);
        check_eq("rd16_done", done_cnt - b_d, 1);
        check_eq("rd16_err", err_cnt - b_e, 0);
        check_eq("rd16_count", rdq.size() - b_rd, 16);
        bad = 0;
        for (int i = 0; i < 16; i++)
            if (b_rd + i >= rdq.size() || rdq[b_rd + i] != 8'(i)) bad++;
        check_eq("rd16_values", bad, 0);
        check_eq("rd16_hdr", (tx_at(b_tx + 1) << 16) | (tx_at(b_tx + 2) << 8) | tx_at(b_tx + 3), 32'h200100);
        rx_byte(8'hEE); rx_byte(8'hEF);
        repeat (2) @(posedge mclk);
        #1;
        check_eq("rd16_extra_ignored", rdq.size() - b_rd, 16);

        // write 0xABCDE, reply header injected between data bytes
        b_tx = txq.size(); b_rd = rdq.size(); b_d = done_cnt; b_e = err_cnt; b_wr = wr_cnt;
        start_cmd(4'd1, 20'hABCDE);
        put_wr(8'h11, 1'b0);
        rx_flg();
        rx_byte(8'h1A); rx_byte(8'hBC); rx_byte(8'hDE);
        put_wr(8'h22, 1'b0);
        put_wr(8'h33, 1'b1);
        wait_end(60, b_d + b_e, hit);
        check_eq("wr_end", int'(hit), 1);
        check_eq("wr_tx_len", txq.size() - b_tx, 8);
        bad = 0;
        if (tx_at(b_tx)     != 32'h100) bad++;
        if (tx_at(b_tx + 1) != 32'h1A)  bad++;
        if (tx_at(b_tx + 2) != 32'hBC)  bad++;
        if (tx_at(b_tx + 3) != 32'hDE)  bad++;
        if (tx_at(b_tx + 4) != 32'h11)  bad++;
        if (tx_at(b_tx + 5) != 32'h22)  bad++;
        if (tx_at(b_tx + 6) != 32'h33)  bad++;
        check_eq("wr_tx_bytes", bad, 0);
        check_eq("wr_tx_close_flag", tx_at(b_tx + 7), 32'h100);
        check_eq("wr_ready_count", wr_cnt - b_wr, 3);
        check_eq("wr_done", done_cnt - b_d, 1);
        check_eq("wr_err", err_cnt - b_e, 0);
        check_eq("wr_rd", rdq.size() - b_rd, 0);

        // read1k with a bad second header byte
        b_rd = rdq.size(); b_d = done_cnt; b_e = err_cnt;
        start_cmd(4'd3, 20'h12345);
        rx_flg();
        rx_byte(8'h31); rx_byte(8'h99);
        wait_end(50, b_d + b_e, hit);
        check_eq("hdr_bad_end", int'(hit), 1);
        check_eq("hdr_bad_err", err_cnt - b_e, 1);
        check_eq("hdr_bad_done", done_cnt - b_d, 0);
        check_eq("hdr_bad_rd", rdq.size() - b_rd, 0);
        repeat (12) @(posedge mclk);
        #1;
        check_eq("hdr_bad_idle", int'(req_ready), 1);

        // read16 reply stalls after 5 bytes -> timeout
        b_rd = rdq.size(); b_d = done_cnt; b_e = err_cnt;
        start_cmd(4'd2, 20'h00100);
        rx_flg();
        rx_byte(8'h20); rx_byte(8'h01); rx_byte(8'h00);
        for (int i = 0; i < 5; i++) rx_byte(8'hA0 + 8'(i));
        wait_end(300, b_d + b_e, hit);
        check_eq("tmo_end", int'(hit), 1);
        check_eq("tmo_rd", rdq.size() - b_rd, 5);
        check_eq("tmo_err", err_cnt - b_e, 1);
        check_eq("tmo_done", done_cnt - b_d, 0);
        check_eq("tmo_delay", err_cyc - last_rd_cyc, 100);
        repeat (4) @(posedge mclk);
        #1;
        check_eq("tmo_idle", int'(req_ready), 1);

        // read64k abandoned by reset after 300 bytes
        b_rd = rdq.size(); b_d = done_cnt; b_e = err_cnt;
        start_cmd(4'd4, 20'h00000);
        rx_flg();
        rx_byte(8'h40); rx_byte(8'h00); rx_byte(8'h00);
        for (int i = 0; i < 300; i++) rx_byte(8'(i));
        @(posedge mclk); #3;
        reset = 1'b1;
        @(negedge mclk); #1;
        check_idle_outputs("mid_reset");
        check_eq("r64k_rd", rdq.size() - b_rd, 300);
        repeat (3) @(posedge mclk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge mclk);
        #1;
        check_eq("r64k_no_done_err", (done_cnt - b_d) + (err_cnt - b_e), 0);

        b_tx = txq.size(); b_d = done_cnt; b_e = err_cnt;
        start_cmd(4'd0, 20'h0ABCD);
        rx_flg();
        rx_byte(8'h00); rx_byte(8'hAB); rx_byte(8'hCD);
        wait_end(60, b_d + b_e, hit);
        check_eq("ping2_end", int'(hit), 1);
        check_eq("ping2_done", done_cnt - b_d, 1);
        check_eq("ping2_tx1", tx_at(b_tx + 2), 32'hAB);

        check_eq("tx_issue_rule", rule_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sio_host.md
Name: sio_host

Overview:
- Initiator end of the escaped-serial memory protocol: issues command packets (flag, {cmd, addr[19:16]}, addr[15:8], addr[7:0], optional write data) and parses the device's reply stream.
- Sits between a local requester (test harness, or board-to-board link controller) and a serial_escaped_uart instance.
- Connects through the same byte/flag interface the device side uses.

Parameters:
- TIMEOUT, 24'd12000000, mclk cycles of reply-side silence before the command is aborted with an error.

Ports:
- mclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  start command (sampled only when req_ready=1)
- req_ready  out  1  high when idle
- req_cmd  in  4  command id (0 ping, 1 write, 2 read16, 3 read1k, 4 read64k)
- req_addr  in  20  start address
- wr_data  in  8  write byte
- wr_valid  in  1  write byte available
- wr_last  in  1  qualifies wr_data as final byte
- wr_ready  out  1  one-cycle pulse: wr_data consumed
- rd_data  out  8  reply data byte
- rd_strobe  out  1  one-cycle pulse: rd_data valid
- done  out  1  one-cycle pulse: command completed cleanly
- err  out  1  one-cycle pulse: command aborted
- tx_ready  in  1  UART can accept a byte or flag
- tx_data  out  8  byte to send
- tx_data_strobe  out  1  send tx_data
- tx_flag  out  1  send flag
- rx_data  in  8  received byte
- rx_data_strobe  in  1  rx_data valid
- rx_flag  in  1  flag received

Behaviour:
- Reset: all outputs 0 except req_ready=1; both FSMs idle; counters 0. Reset mid-command abandons it silently, with no done/err.
- Accept: req_valid && req_ready latches cmd, addr, and reply length. Length is 16 / 1024 / 65536 for cmds 2 / 3 / 4, and 0 otherwise (17-bit). req_ready drops the next cycle.
- TX issue rule: a strobe or flag may be raised only in a cycle where tx_ready=1 and neither tx_data_strobe nor tx_flag was high the previous cycle. Strobes last exactly one cycle.
- TX FSM: IDLE -> FLAG (tx_flag) -> HDR0 ({cmd, addr[19:16]}) -> HDR1 (addr[15:8]) -> HDR2 (addr[7:0]).
  - If cmd=1: -> WDATA, else -> IDLE.
  - WDATA: when the issue rule allows and wr_valid=1, send wr_data and pulse wr_ready in the same cycle. wr_last -> WFLAG.
  - WFLAG sends a closing flag -> IDLE.
  - Write with wr_last never asserted stays in WDATA until err/timeout.
- RX FSM: WAIT_FLAG -> H0 -> H1 -> H2 -> DATA -> FIN.
  - Each H byte must equal the corresponding transmitted header byte; a mismatch raises err.
  - DATA: each rx_data_strobe pulses rd_strobe with rd_data=rx_data the next cycle and decrements the remaining count. Length 0 skips DATA.
  - rx_data_strobe in WAIT_FLAG is ignored.
  - rx_flag in H0..DATA -> err.
  - rx_flag and rx_data_strobe in the same cycle: the flag wins.
- Completion: done pulses one cycle after both the RX FSM is in FIN and the TX FSM is in IDLE. For writes, this means after the closing flag has issued. Then req_ready=1.
- Timeout: counter clears on accept and on any rx strobe/flag, and increments while busy. Reaching TIMEOUT -> err.
- Abort (err): pulse err for one cycle. If the TX FSM was in WDATA, issue a closing flag first. Both FSMs then return to idle. done is never pulsed for an aborted command.
- Data byte count is exact; extra bytes after FIN are ignored until the next accept.
- The reply header may arrive while write data is still transmitting, so the two FSMs run concurrently.

Decomposition:
- Shared package sio_defs, holding:
  - command ids CMD_PING..CMD_READ_64K;
  - reply-length function (cmd -> 17-bit);
  - header field widths;
  - the same constants reused by the device-side protocol block.
- One natural sub-module, sio_host_rx: the reply parser (RX FSM, header compare, data counter, timeout). It takes the expected header bytes and length from the top level, and outputs rd_*, a fin indication, and an error indication.

Test Plan:
- Ping addr 0x12345: TX emits flag, 0x01, 0x23, 0x45. Loopback reply flag, 0x01, 0x23, 0x45 -> done pulse, no rd_strobe, req_ready=1.
- Read16 addr 0x00100: reply header 0x20, 0x01, 0x00, then bytes 0x00..0x0F -> exactly 16 rd_strobe with values 0x00..0x0F, then done.
- Write addr 0xABCDE, data 0x11, 0x22, 0x33 (last on 0x33), with the reply header injected between data bytes -> TX emits flag, 0x1A, 0xBC, 0xDE, 0x11, 0x22, 0x33, flag. Exactly 3 wr_ready pulses, then done.
- Read1k with reply H1=0x99 instead of the expected 0x23 -> err pulse, no done, no rd_strobe.
- TIMEOUT=100, read16, reply stops after 5 data bytes -> 5 rd_strobe, err at 100 cycles after the last byte, then idle.
- Read64k with reset asserted after 300 data bytes -> all outputs return to their reset values, no done/err. A following ping completes normally.
